// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: synchronizes the host link, assembles MSB-first bytes
// and issues one sequential frame-memory write per byte, closing each window with done/error.
module spi_frame_receiver #(
   parameter int unsigned FRAME_BYTES = 12288,
   parameter int unsigned ADDR_WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  spi_cs_n,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy
);

   typedef enum logic [0:0] {IDLE = 1'b0, RECEIVE = 1'b1} state_e;

   localparam logic [ADDR_WIDTH:0] FRAME_LEN = (ADDR_WIDTH+1)'(FRAME_BYTES);
   localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

   logic [2:0]            sclk_q;
   logic [2:0]            cs_q;
   logic [1:0]            mosi_q;
   logic [1:0]            valid_q;
   logic                  armed_q;
   state_e                state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [ADDR_WIDTH:0]   byte_cnt_q, byte_cnt_d;
   logic                  overflow_q, overflow_d;
   logic [6:0]            shift_q, shift_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  busy_q, busy_d;
   logic                  sclk_rise_s, cs_fall_s, cs_rise_s;

   // A cs fall only opens a window once a genuine high level has been seen after reset,
   // so a host still mid-window at reset release is ignored until its next window.
   // Next-state and output decode for the receive FSM.
   always_comb begin
      sclk_rise_s = sclk_q[1] & ~sclk_q[2];
      cs_fall_s   = ~cs_q[1] & cs_q[2] & armed_q;
      cs_rise_s   = cs_q[1] & ~cs_q[2];
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      overflow_d  = overflow_q;
      shift_d     = shift_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall_s) begin
               bit_cnt_d  = 3'd0;
               byte_cnt_d = '0;
               overflow_d = 1'b0;
               state_d    = RECEIVE;
            end else begin
               state_d = IDLE;
            end
         end
         RECEIVE: begin
            if (sclk_rise_s) begin
               shift_d   = {shift_q[5:0], mosi_q[1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q < FRAME_LEN) begin
                     wr_en_d    = 1'b1;
                     wr_data_d  = {shift_q, mosi_q[1]};
                     wr_addr_d  = byte_cnt_q[ADDR_WIDTH-1:0];
                     byte_cnt_d = byte_cnt_q + CNT_ONE;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q;
               end
            end else begin
               shift_d = shift_q;
            end
            // Close uses the counters already updated by a coincident sclk edge.
            if (cs_rise_s) begin
               state_d = IDLE;
               if ((byte_cnt_d == FRAME_LEN) && (bit_cnt_d == 3'd0) && !overflow_d) begin
                  done_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end else begin
               state_d = RECEIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RECEIVE);
   end

   // Synchronizers, FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_q     <= 3'b000;
         cs_q       <= 3'b111;
         mosi_q     <= 2'b00;
         valid_q    <= 2'b00;
         armed_q    <= 1'b0;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= '0;
         overflow_q <= 1'b0;
         shift_q    <= 7'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sclk_q     <= {sclk_q[1:0], spi_sclk};
         cs_q       <= {cs_q[1:0], spi_cs_n};
         mosi_q     <= {mosi_q[0], spi_mosi};
         valid_q    <= {valid_q[0], 1'b1};
         armed_q    <= armed_q | (valid_q[1] & cs_q[1]);
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         overflow_q <= overflow_d;
         shift_q    <= shift_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         error_q    <= error_d;
         busy_q     <= busy_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_done  = done_q;
   assign frame_error = error_q;
   assign busy        = busy_q;

endmodule
